// File: rtl/uart_frame_reader.sv
// Streams one frame over a byte UART: two sync bytes, then ROWS*COLS pixels read
// row by row from a ping-pong line buffer, with buffer swap and frame-done pulses.
module uart_frame_reader #(
  parameter int unsigned COLS  = 160,
  parameter int unsigned ROWS  = 120,
  parameter logic [7:0]  SYNC0 = 8'hAA,
  parameter logic [7:0]  SYNC1 = 8'h55
) (
  input  logic       CLK_UART,
  input  logic       RESET_N,
  input  logic       ENABLE_UART,
  input  logic       ROW_READY,
  input  logic [7:0] PIX_DATA,
  input  logic       TX_READY,
  output logic       BUF_EN_UART,
  output logic       READ_EN_UART,
  output logic [9:0] CNT_ROW_UART,
  output logic       BUF_CHANGE_UART,
  output logic       RESET_FROM_UART,
  output logic [7:0] TX_DATA,
  output logic       TX_VALID,
  output logic       FRAME_DONE
);

  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned ROW_W = 10;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FRM_RST  = 4'd1,
    HDR0     = 4'd2,
    HDR1     = 4'd3,
    ROW_WAIT = 4'd4,
    FETCH    = 4'd5,
    LATCH    = 4'd6,
    SEND     = 4'd7,
    ROW_END  = 4'd8,
    DONE     = 4'd9
  } state_e;

  state_e           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             buf_en_q, buf_en_d;
  logic             read_en_q, read_en_d;
  logic             buf_chg_q, buf_chg_d;
  logic             rst_from_q, rst_from_d;
  logic             tx_valid_q, tx_valid_d;
  logic             done_q, done_d;
  logic             tx_fire;

  assign tx_fire = tx_valid_q & TX_READY;

  // Next state and counters; every output is then decoded from the next state
  // so the registered outputs line up exactly with the state they belong to.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    tx_data_d = tx_data_q;

    unique case (state_q)
      IDLE: if (ENABLE_UART) state_d = FRM_RST;
      FRM_RST: begin
        col_d   = '0;
        row_d   = '0;
        state_d = ENABLE_UART ? HDR0 : IDLE;
      end
      HDR0: if (tx_fire) state_d = ENABLE_UART ? HDR1 : IDLE;
      HDR1: if (tx_fire) state_d = ENABLE_UART ? ROW_WAIT : IDLE;
      ROW_WAIT: begin
        if (!ENABLE_UART)   state_d = IDLE;
        else if (ROW_READY) state_d = FETCH;
      end
      FETCH: state_d = ENABLE_UART ? LATCH : IDLE;
      LATCH: begin
        tx_data_d = PIX_DATA;
        state_d   = ENABLE_UART ? SEND : IDLE;
      end
      SEND: begin
        if (tx_fire) begin
          if (!ENABLE_UART)         state_d = IDLE;
          else if (col_q == COL_LAST) state_d = ROW_END;
          else begin
            col_d   = col_q + COL_W'(1);
            state_d = FETCH;
          end
        end
      end
      ROW_END: begin
        col_d = '0;
        if (!ENABLE_UART)          state_d = IDLE;
        else if (row_q == ROW_LAST) state_d = DONE;
        else begin
          row_d   = row_q + ROW_W'(1);
          state_d = ROW_WAIT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Header bytes load on entry; IDLE forces data and counters to zero.
    case (state_d)
      HDR0: tx_data_d = SYNC0;
      HDR1: tx_data_d = SYNC1;
      IDLE: begin
        tx_data_d = '0;
        col_d     = '0;
        row_d     = '0;
      end
      default: ;
    endcase

    buf_en_d   = (state_d != IDLE);
    read_en_d  = (state_d == FETCH);
    buf_chg_d  = (state_d == ROW_END);
    rst_from_d = (state_d == FRM_RST);
    tx_valid_d = (state_d == HDR0) || (state_d == HDR1) || (state_d == SEND);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge CLK_UART or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      tx_data_q  <= '0;
      buf_en_q   <= 1'b0;
      read_en_q  <= 1'b0;
      buf_chg_q  <= 1'b0;
      rst_from_q <= 1'b0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      tx_data_q  <= tx_data_d;
      buf_en_q   <= buf_en_d;
      read_en_q  <= read_en_d;
      buf_chg_q  <= buf_chg_d;
      rst_from_q <= rst_from_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
    end
  end

  assign BUF_EN_UART     = buf_en_q;
  assign READ_EN_UART    = read_en_q;
  assign CNT_ROW_UART    = row_q;
  assign BUF_CHANGE_UART = buf_chg_q;
  assign RESET_FROM_UART = rst_from_q;
  assign TX_DATA         = tx_data_q;
  assign TX_VALID        = tx_valid_q;
  assign FRAME_DONE      = done_q;

endmodule

// File: doc/uart_frame_reader.md
UART_FRAME_READER -- requirements
Module: uart_frame_reader

Interface
REQ-001 Parameter COLS, default 160, pixels per row.
REQ-002 Parameter ROWS, default 120, rows per frame; maximum 1024.
REQ-003 Parameter SYNC0, default 8'hAA, first header byte.
REQ-004 Parameter SYNC1, default 8'h55, second header byte.
REQ-005 Port CLK_UART, input, 1, single clock; all logic on its rising edge.
REQ-006 Port RESET_N, input, 1, asynchronous active-low reset.
REQ-007 Port ENABLE_UART, input, 1, level request to stream frames.
REQ-008 Port ROW_READY, input, 1, level; the buffer holds a complete row for reading.
REQ-009 Port PIX_DATA, input, 8, buffer read data, valid exactly 1 cycle after READ_EN_UART.
REQ-010 Port TX_READY, input, 1, UART transmitter accepts a byte.
REQ-011 Port BUF_EN_UART, output, 1, buffer enable; high in every state except IDLE.
REQ-012 Port READ_EN_UART, output, 1, one-cycle pixel read strobe.
REQ-013 Port CNT_ROW_UART, output, 10, current row index.
REQ-014 Port BUF_CHANGE_UART, output, 1, one-cycle ping-pong swap pulse at row end.
REQ-015 Port RESET_FROM_UART, output, 1, one-cycle buffer read-pointer reset at frame start.
REQ-016 Port TX_DATA, output, 8, byte to transmit.
REQ-017 Port TX_VALID, output, 1, TX_DATA valid; a byte transfers on the cycle TX_VALID and TX_READY are both high.
REQ-018 Port FRAME_DONE, output, 1, one-cycle pulse after the last pixel is accepted.

Function
REQ-019 The FSM SHALL use states IDLE, FRM_RST, HDR0, HDR1, ROW_WAIT, FETCH, LATCH, SEND, ROW_END and DONE.
REQ-020 IDLE: all outputs low; ENABLE_UART=1 -> FRM_RST.
REQ-021 FRM_RST: RESET_FROM_UART=1 for one cycle; row and column counters cleared -> HDR0.
REQ-022 HDR0/HDR1: TX_VALID=1 with TX_DATA=SYNC0/SYNC1, held until handshake; HDR0 -> HDR1 -> ROW_WAIT.
REQ-023 ROW_WAIT: remain while ROW_READY=0; ROW_READY=1 -> FETCH.
REQ-024 FETCH: READ_EN_UART=1 for exactly one cycle -> LATCH.
REQ-025 LATCH: PIX_DATA registered into TX_DATA -> SEND.
REQ-026 SEND: TX_VALID=1 until handshake; on handshake, column=COLS-1 -> ROW_END, otherwise column+1 -> FETCH.
REQ-027 ROW_END: BUF_CHANGE_UART=1 for one cycle; column cleared; row=ROWS-1 -> DONE, otherwise row+1 -> ROW_WAIT.
REQ-028 DONE: FRAME_DONE=1 for one cycle -> IDLE; ENABLE_UART still high starts the next frame via FRM_RST.
REQ-029 CNT_ROW_UART SHALL equal the row counter, zero-extended to 10 bits; it does not wrap within a frame.
REQ-030 TX_VALID and TX_DATA SHALL NOT change while TX_VALID=1 and TX_READY=0.
REQ-031 ENABLE_UART=0 in ROW_WAIT, FETCH or LATCH -> IDLE on the next edge.
REQ-032 ENABLE_UART=0 in HDR0, HDR1 or SEND: the pending byte completes its handshake, then -> IDLE with no further bytes.
REQ-033 ENABLE_UART=0 in FRM_RST, ROW_END or DONE: that state's pulse completes, then -> IDLE.
REQ-034 TX_READY high with TX_VALID low SHALL have no effect.
REQ-035 Byte order per frame SHALL be SYNC0, SYNC1, then ROWS*COLS pixels, row-major.

Reset
REQ-036 RESET_N=0 SHALL immediately force IDLE, clear both counters, and drive every output to 0, including TX_DATA=8'h00.
REQ-037 Reset mid-frame SHALL discard the frame; after release, streaming restarts from FRM_RST only while ENABLE_UART=1.

Verification
REQ-038 COLS=4, ROWS=2, ROW_READY=1, TX_READY=1, PIX_DATA=column+16*row -> bytes AA,55,00,01,02,03,10,11,12,13; BUF_CHANGE_UART pulses twice; FRAME_DONE pulses once.
REQ-039 TX_READY held 0 for 5 cycles during SEND -> TX_VALID and TX_DATA stable for all 5 cycles, no READ_EN_UART pulse.
REQ-040 ROW_READY=0 for 10 cycles after HDR1 -> no READ_EN_UART pulse; CNT_ROW_UART=0; BUF_EN_UART=1.
REQ-041 ENABLE_UART dropped in SEND with TX_READY=0 -> byte delivered once TX_READY=1, then IDLE; BUF_EN_UART=0 next cycle.
REQ-042 RESET_N pulsed low on the 3rd pixel of row 1 -> outputs 0 asynchronously; with ENABLE_UART=1, next bytes are AA,55 with a RESET_FROM_UART pulse.
REQ-043 Back-to-back frames with ENABLE_UART=1 -> FRAME_DONE, then IDLE, then FRM_RST; CNT_ROW_UART returns to 0.
